// File: rtl/uart_cmd_ctrl.sv
// -----------------------------------------------------------------------------
// uart_cmd_ctrl
// Byte-command controller between an RX FIFO (first-word-fall-through) and a
// TX FIFO. Commands:
//   'L' <hex>  : set the 4-bit LED register, reply 'K' (or 'E' on a bad digit,
//                or 'E' if no argument byte arrives within TIMEOUT_CYCLES)
//   '?'        : reply with the LED value as one uppercase hex digit + LF
//   other      : reply 'E'
// Every 'E' reply bumps a saturating 8-bit error counter.
//
// Optional feature macro: UART_CMD_ECHO_EN -- when defined, each popped byte is
// echoed in front of its reply ('L' echoes alone and then waits for the
// argument).
//
// Ports:
//   clk            single clock
//   rst            synchronous active-high reset
//   rx_data_i[7:0] head byte of the RX FIFO, valid while rx_empty_i=0
//   rx_empty_i     RX FIFO empty
//   rx_rd_en_o     pop strobe; the byte popped is rx_data_i in the same cycle
//   tx_data_o[7:0] byte to the TX FIFO, holds its last written value otherwise
//   tx_wr_en_o     push strobe to the TX FIFO
//   tx_full_i      TX FIFO full
//   led_o[3:0]     LED register
//   err_cnt_o[7:0] count of 'E' replies, saturating at 0xFF
// -----------------------------------------------------------------------------
module uart_cmd_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 100_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data_i,
  input  logic       rx_empty_i,
  output logic       rx_rd_en_o,
  output logic [7:0] tx_data_o,
  output logic       tx_wr_en_o,
  input  logic       tx_full_i,
  output logic [3:0] led_o,
  output logic [7:0] err_cnt_o
);

  localparam int unsigned TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ARG  = 2'd1,
    S_SEND = 2'd2
  } state_e;

  state_e          state_q;
  state_e          ret_q;
  logic [7:0]      buf0_q, buf1_q, buf2_q;
  logic [1:0]      last_q;
  logic [1:0]      idx_q;
  logic [TW-1:0]   tmo_q;
  logic [3:0]      led_q;
  logic [7:0]      err_q;
  logic [7:0]      tx_last_q;

  logic            do_pop;
  logic            do_wr;
  logic            is_l;
  logic [7:0]      tx_sel;
  logic [7:0]      core0, core1;
  logic            core_last;
  logic [7:0]      resp0_d, resp1_d, resp2_d;
  logic [1:0]      resp_last_d;

  function automatic logic is_hex(input logic [7:0] b);
    return ((b >= 8'h30) && (b <= 8'h39)) ||
           ((b >= 8'h41) && (b <= 8'h46)) ||
           ((b >= 8'h61) && (b <= 8'h66));
  endfunction

  // Letters share the low nibble pattern 1..6 in both cases, so +9 maps them to 10..15.
  function automatic logic [3:0] hex_val(input logic [7:0] b);
    return (b <= 8'h39) ? b[3:0] : (b[3:0] + 4'd9);
  endfunction

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? 8'hFF : (v + 8'd1);
  endfunction

  // Pop and push strobes must be same-cycle with the FIFO flags, so they are
  // decoded from registered state and gated by reset.
  assign do_pop = !rst && ((state_q == S_IDLE) || (state_q == S_ARG)) && !rx_empty_i;
  assign do_wr  = !rst && (state_q == S_SEND) && !tx_full_i;
  assign is_l   = (state_q == S_IDLE) && (rx_data_i == 8'h4C);

  assign rx_rd_en_o = do_pop;
  assign tx_wr_en_o = do_wr;
  assign tx_data_o  = do_wr ? tx_sel : tx_last_q;
  assign led_o      = led_q;
  assign err_cnt_o  = err_q;

  // Select the response byte at the current read index.
  always_comb begin
    case (idx_q)
      2'd0:    tx_sel = buf0_q;
      2'd1:    tx_sel = buf1_q;
      default: tx_sel = buf2_q;
    endcase
  end

  // Reply content without echo; a non-popping ARG cycle can only be a timeout.
  always_comb begin
    core0     = 8'h45;
    core1     = 8'h00;
    core_last = 1'b0;
    if ((state_q == S_IDLE) && (rx_data_i == 8'h3F)) begin
      core0     = hex_char(led_q);
      core1     = 8'h0A;
      core_last = 1'b1;
    end else if ((state_q == S_ARG) && do_pop && is_hex(rx_data_i)) begin
      core0 = 8'h4B;
    end else begin
      core0 = 8'h45;
    end
  end

  // Final buffer image, optionally with the popped byte in front.
  always_comb begin
`ifdef UART_CMD_ECHO_EN
    if (do_pop) begin
      resp0_d     = rx_data_i;
      resp1_d     = core0;
      resp2_d     = core1;
      resp_last_d = is_l ? 2'd0 : ({1'b0, core_last} + 2'd1);
    end else begin
      resp0_d     = core0;
      resp1_d     = core1;
      resp2_d     = 8'h00;
      resp_last_d = {1'b0, core_last};
    end
`else
    resp0_d     = core0;
    resp1_d     = core1;
    resp2_d     = 8'h00;
    resp_last_d = {1'b0, core_last};
`endif
  end

  // Command FSM with response buffer, timeout counter, LED and error counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      ret_q     <= S_IDLE;
      buf0_q    <= 8'h00;
      buf1_q    <= 8'h00;
      buf2_q    <= 8'h00;
      last_q    <= 2'd0;
      idx_q     <= 2'd0;
      tmo_q     <= '0;
      led_q     <= 4'h0;
      err_q     <= 8'h00;
      tx_last_q <= 8'h00;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (do_pop) begin
            buf0_q <= resp0_d;
            buf1_q <= resp1_d;
            buf2_q <= resp2_d;
            last_q <= resp_last_d;
            idx_q  <= 2'd0;
            tmo_q  <= '0;
            if (is_l) begin
`ifdef UART_CMD_ECHO_EN
              state_q <= S_SEND;
              ret_q   <= S_ARG;
`else
              state_q <= S_ARG;
              ret_q   <= S_IDLE;
`endif
            end else begin
              state_q <= S_SEND;
              ret_q   <= S_IDLE;
              if (rx_data_i != 8'h3F) begin
                err_q <= sat_inc(err_q);
              end
            end
          end
        end
        S_ARG: begin
          if (do_pop || (tmo_q == TMO_LAST)) begin
            buf0_q  <= resp0_d;
            buf1_q  <= resp1_d;
            buf2_q  <= resp2_d;
            last_q  <= resp_last_d;
            idx_q   <= 2'd0;
            tmo_q   <= '0;
            state_q <= S_SEND;
            ret_q   <= S_IDLE;
            if (do_pop && is_hex(rx_data_i)) begin
              led_q <= hex_val(rx_data_i);
            end else begin
              err_q <= sat_inc(err_q);
            end
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
        end
        S_SEND: begin
          if (do_wr) begin
            tx_last_q <= tx_sel;
            if (idx_q == last_q) begin
              idx_q   <= 2'd0;
              state_q <= ret_q;
            end else begin
              idx_q <= idx_q + 2'd1;
            end
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/uart_cmd_ctrl.md
UART_CMD_CTRL -- requirements
Module: uart_cmd_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 100_000; the number of cycles to wait for an argument byte after 'L' (min 2).
REQ-002 SHALL have port clk, input, 1 bit; single clock for all logic.
REQ-003 SHALL have port rst, input, 1 bit; reset is synchronous and active-high.
REQ-004 SHALL have port rx_data_i, input, 8 bits; head byte of the RX FIFO (first-word-fall-through), valid while rx_empty_i=0.
REQ-005 SHALL have port rx_empty_i, input, 1 bit; RX FIFO empty flag.
REQ-006 SHALL have port rx_rd_en_o, output, 1 bit; one-cycle pop strobe to the RX FIFO.
REQ-007 SHALL have port tx_data_o, output, 8 bits; byte to the TX FIFO, qualified by tx_wr_en_o.
REQ-008 SHALL have port tx_wr_en_o, output, 1 bit; one-cycle push strobe to the TX FIFO.
REQ-009 SHALL have port tx_full_i, input, 1 bit; TX FIFO full flag.
REQ-010 SHALL have port led_o, output, 4 bits; registered LED state.
REQ-011 SHALL have port err_cnt_o, output, 8 bits; count of error responses, saturating at 0xFF.

Function
REQ-012 SHALL implement the FSM states IDLE, ARG and SEND, plus a response buffer of up to 3 bytes with a read index and a return-state register.
REQ-013 SHALL assert rx_rd_en_o only in IDLE or ARG, only when rx_empty_i=0, and for at most one byte per cycle; the popped byte is rx_data_i in that same cycle.
REQ-014 IDLE, byte 0x4C ('L'): SHALL go to ARG and clear the timeout counter (via SEND if the echo buffer is non-empty).
REQ-015 IDLE, byte 0x3F ('?'): SHALL load the response [hex(led_o), 0x0A] and go to SEND with return state IDLE; hex is uppercase ASCII ('0'-'9', 'A'-'F').
REQ-016 IDLE, any other byte: SHALL load the response [0x45] ('E'), go to SEND and increment err_cnt_o.
REQ-017 ARG, byte '0'-'9', 'A'-'F' or 'a'-'f': SHALL update led_o with the nibble value on the next clock edge and respond [0x4B] ('K'), returning to IDLE.
REQ-018 ARG, any other byte: SHALL leave led_o unchanged, respond [0x45] and increment err_cnt_o, returning to IDLE.
REQ-019 ARG timeout: the counter increments each ARG cycle with no pop; on reaching TIMEOUT_CYCLES-1 the block SHALL respond [0x45], increment err_cnt_o and return to IDLE.
REQ-020 A byte arriving in the same cycle as the timeout SHALL win: the byte is popped and decoded, and no timeout occurs.
REQ-021 SEND: SHALL assert tx_wr_en_o with tx_data_o equal to the buffer[index] in each cycle where tx_full_i=0, advance the index, and go to the return state after the last byte.
REQ-022 SEND with tx_full_i=1: SHALL hold tx_wr_en_o=0 and the index, and pop no RX bytes.
REQ-023 Latency: SHALL issue the first tx_wr_en_o in the cycle after the pop when tx_full_i=0 (1 cycle).
REQ-024 SHALL keep err_cnt_o at 0xFF once it reaches 0xFF (saturating).
REQ-025 tx_data_o SHALL hold its last value when tx_wr_en_o=0.

Reset
REQ-026 When rst=1 at a clock edge, the block SHALL enter IDLE and set led_o=0, err_cnt_o=0, tx_data_o=0x00, tx_wr_en_o=0, rx_rd_en_o=0, and clear the timeout counter and buffer index.
REQ-027 Reset during SEND or ARG SHALL drop the pending response; no tx_wr_en_o is issued in the cycle after reset is released.

Configuration
REQ-028 Macro UART_CMD_ECHO_EN, when defined: every popped byte SHALL be prepended to its response (for 'L' in IDLE, the response is [byte] with return state ARG).
REQ-029 When UART_CMD_ECHO_EN is undefined: no echo; 'L' in IDLE SHALL go directly to ARG with no TX write.

Verification
REQ-030 Bytes 'L','5', tx_full_i=0 -> led_o=4'b0101, a single TX write 0x4B, err_cnt_o=0.
REQ-031 Bytes 'L','a', then '?' -> led_o=4'b1010; TX writes 0x4B, 0x41, 0x0A in order.
REQ-032 Bytes 'L','G', then 'x' -> led_o unchanged; TX writes 0x45, 0x45; err_cnt_o=2.
REQ-033 'L' then no bytes for TIMEOUT_CYCLES=16 -> 0x45 written 16 cycles after ARG entry, err_cnt_o=1; a following 'L','3' -> led_o=4'b0011.
REQ-034 '?' with tx_full_i=1 for 50 cycles, and 'L','1' queued in the RX FIFO -> no writes and no pops while full; after release, writes are the hex digit, 0x0A, then 0x4B in order.
REQ-035 With UART_CMD_ECHO_EN defined, bytes 'L','1' -> TX writes 0x4C, 0x31, 0x4B and led_o=4'b0001.
